// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared opcode constants, NOP encoding and forward-select codes for the
// 3-stage hazard controller and its per-stage decode helper.
package pipe_hazard_ctrl_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_CSR       = 7'b1110011;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'd0,
        FWD_S3      = 2'd1,
        FWD_RSVD    = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       writes_rd;
        logic       reads_rs1;
        logic       reads_rs2;
        logic       is_load;
    } dec_t;

endpackage

// File: rtl/pipe_hazard_decode.sv
// Combinational field extraction and register-usage classification for
// one RV32I instruction word.
module pipe_hazard_decode
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] opc;
    logic       unused_bits;

    assign opc         = instr[6:0];
    assign unused_bits = ^{instr[31:25], instr[14:12]};

    always_comb begin
        dec           = '0;
        dec.opcode    = opc;
        dec.rd        = instr[11:7];
        dec.rs1       = instr[19:15];
        dec.rs2       = instr[24:20];
        dec.is_load   = (opc == OPC_LOAD);

        // x0 is never a real destination, so it never counts as a writer
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD,
            OPC_ARI_RTYPE, OPC_ARI_ITYPE, OPC_CSR:
                dec.writes_rd = (instr[11:7] != 5'd0);
            default:
                dec.writes_rd = 1'b0;
        endcase

        dec.reads_rs1 = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
        dec.reads_rs2 = (opc == OPC_ARI_RTYPE) || (opc == OPC_BRANCH) || (opc == OPC_STORE);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 3-stage RV32I core: tracks S2/S3,
// forwarding, redirect, stalls, writeback enable and perf counters.
// Optional load-use stall enabled by defining PIPE_HAZARD_LOAD_USE_STALL_EN.
module pipe_hazard_ctrl #(
    parameter logic [31:0] NOP_INSTR = pipe_hazard_ctrl_pkg::NOP_INSTR,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_s1,
    input  logic             inst_s1_valid,
    input  logic             br_taken_s2,
    input  logic             mem_stall,
    output logic [31:0]      instr_s2,
    output logic [31:0]      instr_s3,
    output logic [1:0]       rs1_fwd_sel,
    output logic [1:0]       rs2_fwd_sel,
    output logic             pc_redirect,
    output logic             stall_s1,
    output logic             wb_en_s3,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    import pipe_hazard_ctrl_pkg::*;

`ifdef PIPE_HAZARD_LOAD_USE_STALL_EN
    localparam bit LOAD_USE_EN = 1'b1;
`else
    localparam bit LOAD_USE_EN = 1'b0;
`endif

    logic [31:0]      instr_s2_q, instr_s2_d;
    logic [31:0]      instr_s3_q, instr_s3_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    dec_t             s2_dec, s3_dec;
    logic             raw_redirect;
    logic             load_use;
    logic             s3_fwd_ok;
    logic             rs1_hit, rs2_hit;
    fwd_sel_e         rs1_sel, rs2_sel;
    logic             unused_dec;

    pipe_hazard_decode u_dec_s2 (
        .instr (instr_s2_q),
        .dec   (s2_dec)
    );

    pipe_hazard_decode u_dec_s3 (
        .instr (instr_s3_q),
        .dec   (s3_dec)
    );

    assign unused_dec = ^{s2_dec.rd, s2_dec.writes_rd, s2_dec.is_load,
                          s3_dec.opcode, s3_dec.rs1, s3_dec.rs2,
                          s3_dec.reads_rs1, s3_dec.reads_rs2};

    // Hazard detection and forwarding; a load in S3 stops forwarding when the
    // load-use stall is built in, since the dependent then replays from S1.
    always_comb begin
        raw_redirect = (s2_dec.opcode == OPC_JAL) || (s2_dec.opcode == OPC_JALR) ||
                       ((s2_dec.opcode == OPC_BRANCH) && br_taken_s2);
        pc_redirect  = raw_redirect && !mem_stall;

        rs1_hit = s2_dec.reads_rs1 && (s3_dec.rd == s2_dec.rs1);
        rs2_hit = s2_dec.reads_rs2 && (s3_dec.rd == s2_dec.rs2);

        load_use  = LOAD_USE_EN && s3_dec.is_load && s3_dec.writes_rd &&
                    (rs1_hit || rs2_hit) && !raw_redirect;
        stall_s1  = mem_stall || load_use;

        s3_fwd_ok = s3_dec.writes_rd && !(LOAD_USE_EN && s3_dec.is_load);
        rs1_sel   = (s3_fwd_ok && rs1_hit) ? FWD_S3 : FWD_REGFILE;
        rs2_sel   = (s3_fwd_ok && rs2_hit) ? FWD_S3 : FWD_REGFILE;
    end

    // Pipeline advance; mem_stall freezes every register including counters.
    always_comb begin
        instr_s2_d     = instr_s2_q;
        instr_s3_d     = instr_s3_q;
        redirect_cnt_d = redirect_cnt_q;
        bubble_cnt_d   = bubble_cnt_q;
        if (!mem_stall) begin
            instr_s3_d = instr_s2_q;
            if (pc_redirect || stall_s1 || !inst_s1_valid) begin
                instr_s2_d = NOP_INSTR;
            end else begin
                instr_s2_d = inst_s1;
            end
            if (pc_redirect) begin
                redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
            end
            if (pc_redirect || load_use) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_s2_q     <= NOP_INSTR;
            instr_s3_q     <= NOP_INSTR;
            redirect_cnt_q <= '0;
            bubble_cnt_q   <= '0;
        end else begin
            instr_s2_q     <= instr_s2_d;
            instr_s3_q     <= instr_s3_d;
            redirect_cnt_q <= redirect_cnt_d;
            bubble_cnt_q   <= bubble_cnt_d;
        end
    end

    assign instr_s2     = instr_s2_q;
    assign instr_s3     = instr_s3_q;
    assign rs1_fwd_sel  = rs1_sel;
    assign rs2_fwd_sel  = rs2_sel;
    assign wb_en_s3     = s3_dec.writes_rd;
    assign redirect_cnt = redirect_cnt_q;
    assign bubble_cnt   = bubble_cnt_q;

endmodule
